io_bus_responder: RTL
=====================

Name: io_bus_responder

Overview:
Memory-mapped peripheral that sits on the processor's data-memory bus (address, write data, write strobe, read strobe, read data) and answers loads and stores in a 16-byte register window at BASE_ADDR.
It buffers outgoing bytes in a TX FIFO that drains to an external device over a valid/ready handshake.
It buffers incoming bytes from an external device in an RX FIFO that software pops by load.
Read data is combinational so the single-cycle core sees it in the same cycle. Its `hit` output drives the top-level read-data mux select, replacing the single-address port compare.

Parameters:
BASE_ADDR, 32'h0000_0800, window base; bits [3:0] must be zero.
DEPTH, 4, entries per FIFO; power of 2, range 2..16.
CW (localparam), $clog2(DEPTH)+1, FIFO count width.

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high
addr  in  32  bus byte address (DataAdr)
wdata  in  32  bus write data
we  in  1  bus write strobe (MemWrite)
re  in  1  bus read strobe (MemtoReg)
rdata  out  32  read data; 0 when !hit
hit  out  1  addr[31:4]==BASE_ADDR[31:4]
tx_data  out  8  TX FIFO head byte
tx_valid  out  1  TX FIFO not empty
tx_ready  in  1  external sink accepts
rx_data  in  8  incoming byte
rx_valid  in  1  incoming byte valid
rx_ready  out  1  RX FIFO has space

Behaviour:
- Register offset = addr[3:2]; addr[1:0] ignored.
- 0x0 TXDATA, write-only:
  - Write pushes wdata[7:0] into TX FIFO.
  - Reads return 0.
- 0x4 RXDATA, read-only:
  - rdata={24'b0, RX head}, or 0 if RX empty.
  - hit & re on a posedge pops the head, if not empty.
  - Writes are ignored.
- 0x8 STATUS, read-only:
  - bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full.
  - bit4 tx_ovf (sticky), bit5 rx_ovf (sticky).
  - [12:8] tx_count, [20:16] rx_count, zero-extended.
  - Other bits 0.
- 0xC CTRL:
  - Write: bit4=1 clears tx_ovf; bit5=1 clears rx_ovf (write-1-to-clear).
  - Write: bits[1:0] load irq_mask.
  - Read returns {30'b0, irq_mask}.
- TX push is accepted iff tx_count<DEPTH, or a TX drain occurs in the same cycle.
  - If not accepted, the byte is dropped and tx_ovf is set.
  - Push+drain in the same cycle leaves count unchanged.
- TX drain occurs when tx_valid & tx_ready at posedge. tx_data is stable while tx_valid & !tx_ready.
- rx_ready = (rx_count<DEPTH) & !reset; it does not depend on a same-cycle CPU pop.
- RX push occurs when rx_valid & rx_ready.
  - rx_valid & !rx_ready sets rx_ovf; that byte is the sender's responsibility.
- A same-cycle RX push and pop both take effect.
- Pointers wrap modulo DEPTH. Counts range 0..DEPTH.
- Latency:
  - Pushed byte appears on tx_data/tx_valid the cycle after the write edge.
  - RX byte is readable via RXDATA the cycle after the accept edge.
- A set and a clear of a sticky flag in the same cycle: set wins.
- Reset, any time including mid-transfer:
  - Both FIFOs are emptied; pointers, counts, sticky flags and irq_mask go to 0.
  - Outputs: tx_valid=0, rx_ready=0 while reset is high, tx_data=0.
  - Data in flight is lost.
- rdata=0 and hit=0 outside the window. we/re outside the window have no effect.

Optional Feature:
IO_RESPONDER_IRQ_EN:
- Adds output irq (1 bit), registered.
- irq = (irq_mask[0] & !rx_empty) | (irq_mask[1] & tx_empty) | tx_ovf | rx_ovf, sampled at posedge; reset value 0.
- Without the macro: no irq port; irq_mask is still readable and writable.

Test Plan:
- Reset, then read 0x808 -> rdata=32'h0000_0006; tx_valid=0; rx_ready=1 after reset falls.
- Store 0x41, 0x42 to 0x800 with tx_ready=0 -> tx_valid=1, tx_data=0x41, STATUS[12:8]=2. Then raise tx_ready 2 cycles -> bytes 0x41 then 0x42 delivered, tx_empty=1.
- DEPTH=4, tx_ready=0, five stores 0x10..0x14 -> FIFO holds 0x10..0x13, STATUS bit4=1. Store 32'h10 to 0x80C -> bit4=0.
- Drive rx_data 0xA5 then 0x5A -> load 0x804 returns 0xA5, next load returns 0x5A, next load returns 0, rx_empty=1.
- Full TX FIFO with tx_ready=1 and a store of 0x77 in the same cycle -> no overflow, count stays 4, 0x77 is the last byte out.
- Assert reset mid-drain with 3 bytes queued -> tx_valid=0 immediately (asynchronous); after release, STATUS=32'h0000_0006.

Source files
------------

// File: rtl/io_bus_responder.sv
// Data-bus peripheral: 16-byte register window with TX and RX byte FIFOs.
// Optional registered interrupt output enabled by IO_RESPONDER_IRQ_EN.
module io_bus_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
`ifdef IO_RESPONDER_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_tx_mem [DEPTH];
    logic [7:0]    r_rx_mem [DEPTH];
    logic [AW-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    logic [CW-1:0] r_tx_cnt, r_rx_cnt;
    logic          r_tx_ovf, r_rx_ovf;
    logic [1:0]    r_irq_mask;

    logic [1:0]  w_sel;
    logic        w_tx_wr, w_ctrl_wr;
    logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic        w_tx_push, w_tx_drain, w_tx_ovf_set;
    logic        w_rx_push, w_rx_pop, w_rx_ovf_set;
    logic [31:0] w_status;
    logic        w_unused;

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_sel     = addr[3:2];
    assign w_tx_wr   = hit & we & (w_sel == 2'd0);
    assign w_ctrl_wr = hit & we & (w_sel == 2'd3);

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == CW'(DEPTH));
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == CW'(DEPTH));

    assign tx_valid     = !w_tx_empty;
    assign tx_data      = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd];
    assign w_tx_drain   = tx_valid & tx_ready;
    // A drain in the same cycle frees the slot the push needs.
    assign w_tx_push    = w_tx_wr & (!w_tx_full | w_tx_drain);
    assign w_tx_ovf_set = w_tx_wr & !w_tx_push;

    assign rx_ready     = !w_rx_full & !reset;
    assign w_rx_push    = rx_valid & rx_ready;
    assign w_rx_ovf_set = rx_valid & !rx_ready;
    assign w_rx_pop     = hit & re & (w_sel == 2'd1) & !w_rx_empty;

    assign w_status = {11'b0, 5'(r_rx_cnt), 3'b0, 5'(r_tx_cnt), 2'b0,
                       r_rx_ovf, r_tx_ovf, w_rx_full, w_rx_empty,
                       w_tx_empty, w_tx_full};

    assign w_unused = ^{wdata[31:8], addr[1:0]};

    always_comb begin
        rdata = '0;
        if (hit) begin
            unique case (w_sel)
                2'd0: rdata = '0;
                2'd1: rdata = w_rx_empty ? 32'h0 : {24'b0, r_rx_mem[r_rx_rd]};
                2'd2: rdata = w_status;
                2'd3: rdata = {30'b0, r_irq_mask};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= wdata[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_wr    <= '0;
            r_tx_rd    <= '0;
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
            r_tx_ovf   <= 1'b0;
            r_rx_ovf   <= 1'b0;
            r_irq_mask <= 2'b00;
        end else begin
            if (w_tx_push)  r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_drain) r_tx_rd <= r_tx_rd + 1'b1;
            if (w_rx_push)  r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)   r_rx_rd <= r_rx_rd + 1'b1;
            r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_drain);
            r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
            // Sticky flags: a set in the same cycle as a clear wins.
            if (w_tx_ovf_set)
                r_tx_ovf <= 1'b1;
            else if (w_ctrl_wr && wdata[4])
                r_tx_ovf <= 1'b0;
            if (w_rx_ovf_set)
                r_rx_ovf <= 1'b1;
            else if (w_ctrl_wr && wdata[5])
                r_rx_ovf <= 1'b0;
            if (w_ctrl_wr) r_irq_mask <= wdata[1:0];
        end
    end

`ifdef IO_RESPONDER_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= (r_irq_mask[0] & !w_rx_empty) |
                   (r_irq_mask[1] & w_tx_empty) | r_tx_ovf | r_rx_ovf;
    end
`endif

endmodule
